// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: two-entry skid pipeline register with registered in_ready and flush.
// Optional macro PIPE_STAGE_STALL_CNT_EN enables the saturating backpressure counter on stall_cnt.
module pipe_stage_reg #(
    parameter int DATA_W = 16,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
    state_t state, state_nxt;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
    logic [DATA_W-1:0] main_data, skid_data;
    logic accept, drain;
    assign in_ready  = state != FULL;
    assign out_valid = state != EMPTY;
    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;
    assign out_ctrl  = out_valid ? main_ctrl : '0;
    assign out_data  = main_data;
    always_comb begin
        state_nxt = state;
        if (flush)
            state_nxt = EMPTY;
        else if (state == EMPTY)
            state_nxt = accept ? ONE : EMPTY;
        else if (state == ONE)
            state_nxt = (accept && !drain) ? FULL : (!accept && drain) ? EMPTY : ONE;
        else
            state_nxt = drain ? ONE : FULL;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= EMPTY;
        else
            state <= state_nxt;
    end
    // Main takes the new entry when it is free or draining this edge; otherwise it refills from skid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_ctrl <= '0;
            main_data <= '0;
            skid_ctrl <= '0;
            skid_data <= '0;
        end else if (!flush) begin
            if (accept && (state == EMPTY || drain)) begin
                main_ctrl <= in_ctrl;
                main_data <= in_data;
            end else if (state == FULL && drain) begin
                main_ctrl <= skid_ctrl;
                main_data <= skid_data;
            end
            if (accept && state == ONE && !drain) begin
                skid_ctrl <= in_ctrl;
                skid_data <= in_data;
            end
        end
    end
`ifdef PIPE_STAGE_STALL_CNT_EN
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (out_valid && !out_ready && cnt != '1)
            cnt <= cnt + 1'b1;
    end
    assign stall_cnt = cnt;
`else
    assign stall_cnt = '0;
`endif
endmodule
